// File: rtl/funcao_g_if.sv
// Handshake bundle for the AES key-expansion g function: input word/round with
// a valid strobe, and the registered result with its own valid strobe.
interface funcao_g_if;
  logic [31:0] palavra;
  logic [3:0]  rodada;
  logic        entrada_valida;
  logic [31:0] saida;
  logic        saida_valida;

  modport master (
    output palavra,
    output rodada,
    output entrada_valida,
    input  saida,
    input  saida_valida
  );

  modport slave (
    input  palavra,
    input  rodada,
    input  entrada_valida,
    output saida,
    output saida_valida
  );
endinterface

// File: rtl/funcao_g.sv
// AES key-expansion g function: RotWord, SubWord, Rcon XOR; one-cycle registered result.
// Optional FUNCAO_G_RODADA_ERRO_EN adds a registered rodada_erro flag for rodada >= 10.
module funcao_g (
  input  logic     clk,
  input  logic     rst_n,
  funcao_g_if.slave bus
`ifdef FUNCAO_G_RODADA_ERRO_EN
  ,
  output logic     rodada_erro
`endif
);

  // FIPS-197 forward S-box, byte 0x00 at the most significant position.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [31:0] rot;
  logic [31:0] sub;
  logic [7:0]  rcon;
  logic [31:0] g_word;

  always_comb begin
    rot = {bus.palavra[23:0], bus.palavra[31:24]};
    sub = {SBOX[rot[31:24]], SBOX[rot[23:16]], SBOX[rot[15:8]], SBOX[rot[7:0]]};
    unique case (bus.rodada)
      4'd0:    rcon = 8'h01;
      4'd1:    rcon = 8'h02;
      4'd2:    rcon = 8'h04;
      4'd3:    rcon = 8'h08;
      4'd4:    rcon = 8'h10;
      4'd5:    rcon = 8'h20;
      4'd6:    rcon = 8'h40;
      4'd7:    rcon = 8'h80;
      4'd8:    rcon = 8'h1b;
      4'd9:    rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
    g_word = sub ^ {rcon, 24'h000000};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.saida        <= '0;
      bus.saida_valida <= 1'b0;
    end else begin
      bus.saida_valida <= bus.entrada_valida;
      if (bus.entrada_valida) begin
        bus.saida <= g_word;
      end
    end
  end

`ifdef FUNCAO_G_RODADA_ERRO_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rodada_erro <= 1'b0;
    end else if (bus.entrada_valida) begin
      rodada_erro <= (bus.rodada >= 4'd10);
    end
  end
`endif

endmodule

// File: tb/tb_funcao_g.sv
// Self-checking bench for funcao_g: directed vectors plus randomized traffic
// against a model that derives the S-box from GF(2^8) inversion and the affine map.
module tb_funcao_g;

  logic clk;
  logic rst_n;
  funcao_g_if bus ();

`ifdef FUNCAO_G_RODADA_ERRO_EN
  logic rodada_erro;
  funcao_g dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave), .rodada_erro(rodada_erro));
`else
  funcao_g dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned checks;
  int unsigned failures;

  logic [7:0] sbox_ref [256];

  logic [31:0] exp_saida;
  logic        exp_valida;
  logic        exp_erro;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int unsigned n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  function automatic logic [7:0] rcon_ref(input logic [3:0] r);
    logic [7:0] rc;
    if (r >= 4'd10) return 8'h00;
    rc = 8'h01;
    for (int unsigned i = 0; i < r; i++) rc = gmul(rc, 8'h02);
    return rc;
  endfunction

  function automatic logic [31:0] g_ref(input logic [31:0] w, input logic [3:0] r);
    logic [7:0] b [4];
    logic [31:0] res;
    // RotWord: byte order (w2, w1, w0, w3) from most to least significant
    b[3] = w[23:16];
    b[2] = w[15:8];
    b[1] = w[7:0];
    b[0] = w[31:24];
    res = {sbox_ref[b[3]], sbox_ref[b[2]], sbox_ref[b[1]], sbox_ref[b[0]]};
    res[31:24] = res[31:24] ^ rcon_ref(r);
    return res;
  endfunction

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  // Apply one cycle of stimulus, advance the model, then sample just after the edge.
  task automatic step(input logic rst, input logic v, input logic [31:0] p, input logic [3:0] r);
    rst_n              = rst;
    bus.entrada_valida = v;
    bus.palavra        = p;
    bus.rodada         = r;
    @(posedge clk);
    if (!rst) begin
      exp_saida  = 32'h0;
      exp_valida = 1'b0;
      exp_erro   = 1'b0;
    end else if (v) begin
      exp_saida  = g_ref(p, r);
      exp_valida = 1'b1;
      exp_erro   = (r >= 4'd10);
    end else begin
      exp_valida = 1'b0;
    end
    #1;
    check32("saida", bus.saida, exp_saida);
    check1("saida_valida", bus.saida_valida, exp_valida);
`ifdef FUNCAO_G_RODADA_ERRO_EN
    check1("rodada_erro", rodada_erro, exp_erro);
`endif
  endtask

  initial begin
    logic [7:0] inv;
    logic [7:0] sweep_hi [10];
    checks     = 0;
    failures   = 0;
    exp_saida  = '0;
    exp_valida = 1'b0;
    exp_erro   = 1'b0;

    for (int unsigned a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int unsigned c = 1; c < 256; c++) begin
        if (gmul(8'(a), 8'(c)) == 8'h01) inv = 8'(c);
      end
      sbox_ref[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end

    rst_n = 1'b0;
    bus.entrada_valida = 1'b0;
    bus.palavra = '0;
    bus.rodada = '0;

    step(1'b0, 1'b0, 32'h0, 4'd0);
    step(1'b0, 1'b1, 32'hdeadbeef, 4'd3);
    check32("reset_saida", bus.saida, 32'h00000000);

    step(1'b1, 1'b1, 32'he6ffd3c6, 4'd2);
    check32("vec_e6ffd3c6", bus.saida, 32'h1266b48e);
    step(1'b1, 1'b1, 32'h09cf4f3c, 4'd0);
    check32("vec_fips_first", bus.saida, 32'h8b84eb01);
    step(1'b1, 1'b1, 32'h00000000, 4'd9);
    check32("vec_rodada9", bus.saida, 32'h55636363);
    step(1'b1, 1'b1, 32'h00000000, 4'd12);
    check32("vec_rodada12", bus.saida, 32'h63636363);
`ifdef FUNCAO_G_RODADA_ERRO_EN
    check1("vec_rodada12_erro", rodada_erro, 1'b1);
`endif
    step(1'b1, 1'b0, 32'hffffffff, 4'd1);
    check32("hold_saida", bus.saida, 32'h63636363);

    sweep_hi = '{8'h62, 8'h61, 8'h67, 8'h6b, 8'h73, 8'h43, 8'h23, 8'he3, 8'h78, 8'h55};
    for (int unsigned r = 0; r < 10; r++) begin
      step(1'b1, 1'b1, 32'h00000000, 4'(r));
      check32("sweep", bus.saida, {sweep_hi[r], 24'h636363});
    end

    step(1'b0, 1'b1, 32'h12345678, 4'd4);
    check32("midreset_saida", bus.saida, 32'h00000000);
    check1("midreset_valida", bus.saida_valida, 1'b0);
    step(1'b1, 1'b0, 32'h12345678, 4'd4);
    check32("postreset_hold", bus.saida, 32'h00000000);
    step(1'b1, 1'b1, 32'h09cf4f3c, 4'd0);
    check32("postreset_first", bus.saida, 32'h8b84eb01);

    for (int unsigned n = 0; n < 300; n++) begin
      step($urandom_range(0, 19) != 0, $urandom_range(0, 3) != 0,
           $urandom, 4'($urandom_range(0, 15)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
